ndn_data_producer: RTL and testbench
====================================

# ndn_data_producer

Upstream content producer for the NDN router: the responder at the far end of the interest/data exchange. It accepts forwarded interests (prefix, length, ready strobe) from the router's FIB egress and searches a small programmable content table. On a hit it returns a data packet as a framed byte stream (prefix, length, ready, one byte per cycle) into the router's data-in port; on a miss it raises a one-cycle NACK.

## Interface
Parameters:
- ENTRIES, 8, number of content-table entries (power of two, ≥2)
- MAX_BYTES, 16, maximum content bytes per entry (power of two)
- Derived: EW = $clog2(ENTRIES), BW = $clog2(MAX_BYTES), CLW = BW+1

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- interest_valid  in  1  interest strobe (driven by router ready_for_data)
- interest_prefix  in  64  requested name prefix
- interest_len  in  6  requested prefix length
- hdr_we  in  1  write entry header
- byte_we  in  1  write one content byte
- ld_entry  in  EW  target entry for hdr_we/byte_we
- ld_prefix  in  64  header prefix
- ld_len  in  6  header prefix length
- ld_content_len  in  CLW  content byte count; 0 invalidates entry
- ld_addr  in  BW  content byte index
- ld_byte  in  8  content byte value
- data_prefix  out  64  prefix of packet being returned
- data_len  out  6  prefix length of packet being returned
- data_ready  out  1  high while data_out carries valid content bytes
- data_out  out  8  content byte stream
- nack  out  1  one-cycle pulse: no entry matched
- busy  out  1  high in SEARCH or STREAM
- drop_count  out  8  saturating count of interests dropped while busy

## Operation
- FSM states: IDLE, SEARCH, STREAM.
- IDLE: if interest_valid, register prefix/len, idx←0, go SEARCH. Loads are accepted only in IDLE; hdr_we/byte_we while busy are ignored.
- SEARCH: compare entry idx (valid, prefix equal on all 64 bits, len equal).
  - Hit: latch data_prefix/data_len, remaining←content_len, issue RAM read of byte 0, go STREAM.
  - Miss, idx==ENTRIES-1: pulse nack, go IDLE.
  - Otherwise idx←idx+1.
  - Scanning ascending means the lowest-index matching entry wins.
- STREAM: data_ready=1, data_out=current byte, read address increments each cycle; after content_len bytes go IDLE, data_ready→0.
- interest_valid outside IDLE: interest discarded, drop_count+1 (saturates at 255). Simultaneous with the IDLE exit cycle counts as a drop.
- hdr_we and byte_we in the same cycle: both performed.
- ld_content_len > MAX_BYTES: clamped to MAX_BYTES.
- Reset (any time, including mid-stream): FSM→IDLE, all valid bits cleared, all outputs 0, drop_count 0. Content RAM contents are not cleared.

## Timing
- Interest sampled at edge T; entry k is examined in cycle T+1+k.
- Hit at k: first byte with data_ready=1 in cycle T+2+k; byte n in cycle T+2+k+n; data_ready deasserts after the last byte. No gaps between bytes.
- Miss: nack high in cycle T+ENTRIES only; busy low from T+ENTRIES+1.
- data_prefix/data_len stable for the whole STREAM; they hold their last value afterwards.
- Back-to-back: a new interest is accepted in the first IDLE cycle after STREAM or nack.
- Header/byte writes take effect on the next edge and are visible to an interest sampled in the same cycle as the write.

## Structure
- Shared package ndn_pkg: PREFIX_W=64, LEN_W=6, BYTE_W=8, state enum {IDLE,SEARCH,STREAM}.
- Sub-module producer_content_ram: ENTRIES×MAX_BYTES×8 synchronous RAM, one write port and one read port, 1-cycle read latency, address {entry,byte}.
- The header table (valid, prefix, len, content_len) is held in flops in the top module.

## Test plan
- Load entry 2 (prefix 0xA5A5_0000_0000_1234, len 16, bytes 11,22,33,44) and issue a matching interest at T → data_ready in cycles T+4..T+7 with data_out 11,22,33,44, data_prefix/len as loaded, nack never asserted.
- Interest for an unloaded prefix → nack exactly in cycle T+8 (ENTRIES=8), data_ready never asserted, busy low at T+9.
- Entries 1 and 5 both match, with content 0xAA and 0xBB → entry 1 is streamed (0xAA) starting at T+3.
- Second interest mid-STREAM → stream is unaffected, drop_count=1; 256 such interests → drop_count=255.
- hdr_we with ld_content_len=0 on entry 2, then the same interest → nack; hdr_we while busy → entry unchanged.
- rst asserted low on the second streamed byte → data_ready, nack, busy, and drop_count are 0 immediately (asynchronous); after release the prior interest → nack (valid bits cleared).

Source files
------------

// File: rtl/ndn_pkg.sv
// Shared widths and FSM encoding for the NDN data producer.
package ndn_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    STREAM
  } state_e;

endpackage

// File: rtl/producer_content_ram.sv
// Content byte store: one write port, one read port, registered read data.
module producer_content_ram
  import ndn_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int MAX_BYTES = 16,
  localparam int AW       = $clog2(ENTRIES * MAX_BYTES)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [ENTRIES * MAX_BYTES];
  logic [BYTE_W-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; consumers gate rdata with their own reset-cleared state.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ndn_data_producer.sv
// Content producer: linear search of a header table, then stream the hit's
// bytes out of the content RAM; NACK on a full miss.
module ndn_data_producer
  import ndn_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int MAX_BYTES = 16,
  localparam int EW       = $clog2(ENTRIES),
  localparam int BW       = $clog2(MAX_BYTES),
  localparam int CLW      = BW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interest_valid,
  input  logic [PREFIX_W-1:0] interest_prefix,
  input  logic [LEN_W-1:0]    interest_len,
  input  logic                hdr_we,
  input  logic                byte_we,
  input  logic [EW-1:0]       ld_entry,
  input  logic [PREFIX_W-1:0] ld_prefix,
  input  logic [LEN_W-1:0]    ld_len,
  input  logic [CLW-1:0]      ld_content_len,
  input  logic [BW-1:0]       ld_addr,
  input  logic [BYTE_W-1:0]   ld_byte,
  output logic [PREFIX_W-1:0] data_prefix,
  output logic [LEN_W-1:0]    data_len,
  output logic                data_ready,
  output logic [BYTE_W-1:0]   data_out,
  output logic                nack,
  output logic                busy,
  output logic [7:0]          drop_count
);

  state_e              state_q, state_d;
  logic [EW-1:0]       idx_q, idx_d;
  logic [PREFIX_W-1:0] req_prefix_q, req_prefix_d;
  logic [LEN_W-1:0]    req_len_q, req_len_d;
  logic [CLW-1:0]      remaining_q, remaining_d;
  logic [BW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PREFIX_W-1:0] data_prefix_q, data_prefix_d;
  logic [LEN_W-1:0]    data_len_q, data_len_d;
  logic [7:0]          drop_q, drop_d;

  logic [ENTRIES-1:0]  valid_q;
  logic [PREFIX_W-1:0] hdr_prefix_q [ENTRIES];
  logic [LEN_W-1:0]    hdr_len_q    [ENTRIES];
  logic [CLW-1:0]      hdr_clen_q   [ENTRIES];

  logic [CLW-1:0]      ld_clen_clamped;
  logic                idle;
  logic                hit;
  logic [EW+BW-1:0]    raddr;
  logic [BYTE_W-1:0]   rdata;

  assign idle            = (state_q == IDLE);
  assign ld_clen_clamped = (ld_content_len > CLW'(MAX_BYTES)) ? CLW'(MAX_BYTES) : ld_content_len;
  assign hit             = valid_q[idx_q] && (hdr_prefix_q[idx_q] == req_prefix_q)
                           && (hdr_len_q[idx_q] == req_len_q);

  // Table loads are only honoured in IDLE so a search never sees a half-written entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        hdr_prefix_q[i] <= '0;
        hdr_len_q[i]    <= '0;
        hdr_clen_q[i]   <= '0;
      end
    end else if (hdr_we && idle) begin
      valid_q[ld_entry]      <= (ld_content_len != '0);
      hdr_prefix_q[ld_entry] <= ld_prefix;
      hdr_len_q[ld_entry]    <= ld_len;
      hdr_clen_q[ld_entry]   <= ld_clen_clamped;
    end
  end

  producer_content_ram #(
    .ENTRIES   (ENTRIES),
    .MAX_BYTES (MAX_BYTES)
  ) u_ram (
    .clk     (clk),
    .we_i    (byte_we && idle),
    .waddr_i ({ld_entry, ld_addr}),
    .wdata_i (ld_byte),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred; blocking '=' is correct here.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    req_prefix_d  = req_prefix_q;
    req_len_d     = req_len_q;
    remaining_d   = remaining_q;
    rd_ptr_d      = rd_ptr_q;
    data_prefix_d = data_prefix_q;
    data_len_d    = data_len_q;
    raddr         = {idx_q, rd_ptr_q};
    nack          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (interest_valid) begin
          req_prefix_d = interest_prefix;
          req_len_d    = interest_len;
          idx_d        = '0;
          state_d      = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          data_prefix_d = hdr_prefix_q[idx_q];
          data_len_d    = hdr_len_q[idx_q];
          remaining_d   = hdr_clen_q[idx_q];
          raddr         = {idx_q, BW'(0)};
          rd_ptr_d      = BW'(1);
          state_d       = STREAM;
        end else if (idx_q == EW'(ENTRIES - 1)) begin
          nack    = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + EW'(1);
        end
      end
      STREAM: begin
        // RAM data lags its address by one cycle, so fetch one byte ahead.
        rd_ptr_d    = rd_ptr_q + BW'(1);
        remaining_d = remaining_q - CLW'(1);
        if (remaining_q == CLW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (interest_valid && !idle && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      req_prefix_q  <= '0;
      req_len_q     <= '0;
      remaining_q   <= '0;
      rd_ptr_q      <= '0;
      data_prefix_q <= '0;
      data_len_q    <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      req_prefix_q  <= req_prefix_d;
      req_len_q     <= req_len_d;
      remaining_q   <= remaining_d;
      rd_ptr_q      <= rd_ptr_d;
      data_prefix_q <= data_prefix_d;
      data_len_q    <= data_len_d;
      drop_q        <= drop_d;
    end
  end

  assign busy        = !idle;
  assign data_ready  = (state_q == STREAM);
  assign data_out    = data_ready ? rdata : '0;
  assign data_prefix = data_prefix_q;
  assign data_len    = data_len_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_ndn_data_producer.sv
// Self-checking bench for ndn_data_producer: fixed vector table, corner-case
// sequences and randomized traffic against a transaction-level model.
module tb_ndn_data_producer;
  import ndn_pkg::*;

  localparam int ENTRIES   = 8;
  localparam int MAX_BYTES = 16;
  localparam int EW        = 3;
  localparam int BW        = 4;
  localparam int CLW       = 5;
  localparam int NCYC      = ENTRIES + MAX_BYTES + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                interest_valid = 1'b0;
  logic [PREFIX_W-1:0] interest_prefix = '0;
  logic [LEN_W-1:0]    interest_len = '0;
  logic                hdr_we = 1'b0;
  logic                byte_we = 1'b0;
  logic [EW-1:0]       ld_entry = '0;
  logic [PREFIX_W-1:0] ld_prefix = '0;
  logic [LEN_W-1:0]    ld_len = '0;
  logic [CLW-1:0]      ld_content_len = '0;
  logic [BW-1:0]       ld_addr = '0;
  logic [BYTE_W-1:0]   ld_byte = '0;
  logic [PREFIX_W-1:0] data_prefix;
  logic [LEN_W-1:0]    data_len;
  logic                data_ready;
  logic [BYTE_W-1:0]   data_out;
  logic                nack;
  logic                busy;
  logic [7:0]          drop_count;

  ndn_data_producer #(.ENTRIES(ENTRIES), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst),
    .interest_valid(interest_valid), .interest_prefix(interest_prefix), .interest_len(interest_len),
    .hdr_we(hdr_we), .byte_we(byte_we), .ld_entry(ld_entry), .ld_prefix(ld_prefix), .ld_len(ld_len),
    .ld_content_len(ld_content_len), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .data_prefix(data_prefix), .data_len(data_len), .data_ready(data_ready), .data_out(data_out),
    .nack(nack), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: table contents, drop counter, and a chaining flag.
  bit              m_valid [ENTRIES];
  logic [63:0]     m_prefix[ENTRIES];
  logic [5:0]      m_len   [ENTRIES];
  int              m_clen  [ENTRIES];
  logic [7:0]      m_mem   [ENTRIES][MAX_BYTES];
  int              m_drop = 0;
  bit              pending_chain = 0;

  localparam logic [63:0] PA   = 64'hA5A5_0000_0000_1234;
  localparam logic [63:0] P2   = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] P3   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PNEW = 64'h5555_AAAA_5555_AAAA;
  localparam logic [63:0] PMIS = 64'hFFFF_0000_FFFF_0000;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_lookup(input logic [63:0] p, input logic [5:0] l);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_prefix[i] == p && m_len[i] == l) return i;
    return -1;
  endfunction

  task automatic load_cycle(input bit hw, input bit bw, input int e, input logic [63:0] p,
                            input logic [5:0] l, input int clen, input int a, input logic [7:0] b);
    pending_chain = 0;
    @(negedge clk);
    hdr_we = hw; byte_we = bw; ld_entry = e[EW-1:0]; ld_prefix = p; ld_len = l;
    ld_content_len = CLW'(clen); ld_addr = a[BW-1:0]; ld_byte = b;
    @(posedge clk); #1;
    hdr_we = 0; byte_we = 0;
    if (hw) begin
      m_prefix[e] = p; m_len[e] = l;
      m_clen[e]   = (clen > MAX_BYTES) ? MAX_BYTES : clen;
      m_valid[e]  = (clen != 0);
    end
    if (bw) m_mem[e][a] = b;
  endtask

  task automatic load_entry(input int e, input logic [63:0] p, input logic [5:0] l,
                            input int clen, input int nb, input logic [7:0] bytes[MAX_BYTES]);
    load_cycle(1, nb > 0, e, p, l, clen, 0, bytes[0]);
    for (int a = 1; a < nb; a++) load_cycle(0, 1, e, p, l, clen, a, bytes[a]);
  endtask

  // Issues one interest and checks every following cycle against the model's
  // timing: entry k examined at cycle 1+k, bytes at k+2.., nack at ENTRIES.
  task automatic run_interest(input logic [63:0] p, input logic [5:0] l,
                              input logic [NCYC:0] drop_mask, input bit chain,
                              output int first_c, output int first_b,
                              output int nbytes, output int nack_c);
    int k, last_busy;
    bit e_busy, e_rdy, e_nack;
    logic [7:0] exp_out;
    k = model_lookup(p, l);
    last_busy = (k < 0) ? ENTRIES : k + 1 + m_clen[k];
    first_c = 0; first_b = -1; nbytes = 0; nack_c = 0;
    if (!pending_chain) @(negedge clk);
    pending_chain = 0;
    interest_prefix = p; interest_len = l; interest_valid = 1;
    @(posedge clk); #1;
    interest_valid = 0;
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      e_busy  = (c <= last_busy);
      e_rdy   = (k >= 0) && (c >= k + 2) && (c <= last_busy);
      e_nack  = (k < 0) && (c == ENTRIES);
      exp_out = 8'h00;
      if (e_rdy) exp_out = m_mem[k][c-k-2];
      check($sformatf("cyc%0d busy/rdy/nack/out", c), {busy, data_ready, nack, data_out},
            {e_busy, e_rdy, e_nack, exp_out});
      if (e_rdy) check($sformatf("cyc%0d data_prefix/len", c), {data_prefix, data_len},
                       {m_prefix[k], m_len[k]});
      if (data_ready) begin
        if (first_c == 0) begin first_c = c; first_b = int'(data_out); end
        nbytes++;
      end
      if (nack && nack_c == 0) nack_c = c;
      if (chain && !e_busy) begin
        pending_chain = 1;
        break;
      end
      interest_valid = drop_mask[c] && e_busy;
      if (interest_valid) begin
        interest_prefix = {$urandom, $urandom};
        if (m_drop < 255) m_drop++;
      end
    end
    interest_valid = 0;
    check("drop_count", drop_count, m_drop);
  endtask

  typedef struct {
    string       name;
    logic [63:0] p;
    logic [5:0]  l;
    int          first_c;
    int          first_b;
    int          nbytes;
    int          nack_c;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes[MAX_BYTES];
    logic [63:0] pool[4];
    logic [NCYC:0] rmask;
    int fc, fb, nb, nc, guard;

    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_prefix[i] = '0; m_len[i] = '0; m_clen[i] = 0;
      for (int a = 0; a < MAX_BYTES; a++) m_mem[i][a] = 8'h00;
    end

    #12;
    check("reset outputs", {data_prefix, data_len, data_ready, data_out, nack, busy, drop_count},
          '0);
    #10 rst = 1;

    bytes = '{default: 8'h00};
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    load_entry(2, PA, 6'd16, 4, 4, bytes);
    bytes[0] = 8'hAA;
    load_entry(1, P2, 6'd32, 1, 1, bytes);
    bytes[0] = 8'hBB;
    load_entry(5, P2, 6'd32, 1, 1, bytes);
    for (int a = 0; a < MAX_BYTES; a++) bytes[a] = 8'(a * 3 + 1);
    load_entry(7, P3, 6'd8, 31, MAX_BYTES, bytes);

    vecs[0] = '{"hit_entry2",   PA,          6'd16, 4, 8'h11, 4,  0};
    vecs[1] = '{"len_mismatch", PA,          6'd15, 0, -1,    0,  8};
    vecs[2] = '{"lowest_wins",  P2,          6'd32, 3, 8'hAA, 1,  0};
    vecs[3] = '{"last_clamped", P3,          6'd8,  9, 8'h01, 16, 0};
    vecs[4] = '{"prefix_bit0",  PA ^ 64'h1,  6'd16, 0, -1,    0,  8};
    vecs[5] = '{"zero_unused",  64'h0,       6'd0,  0, -1,    0,  8};
    for (int i = 0; i < 6; i++) begin
      run_interest(vecs[i].p, vecs[i].l, '0, 0, fc, fb, nb, nc);
      check({vecs[i].name, " start"}, fc, vecs[i].first_c);
      check({vecs[i].name, " byte0"}, fb, vecs[i].first_b);
      check({vecs[i].name, " nbytes"}, nb, vecs[i].nbytes);
      check({vecs[i].name, " nack_cyc"}, nc, vecs[i].nack_c);
    end

    // Interest during the stream is dropped without disturbing the bytes.
    run_interest(PA, 6'd16, (NCYC+1)'(1 << 5), 0, fc, fb, nb, nc);
    check("drop_one", drop_count, 8'd1);
    check("drop_one nbytes", nb, 4);

    // 256 more dropped interests saturate the counter.
    for (int i = 0; i < 32; i++) run_interest(PMIS, 6'd4, (NCYC+1)'(9'h1FE), 0, fc, fb, nb, nc);
    check("drop_sat", drop_count, 8'd255);

    // A new interest is taken in the first IDLE cycle after a nack.
    run_interest(PMIS, 6'd4, '0, 1, fc, fb, nb, nc);
    run_interest(PA, 6'd16, '0, 0, fc, fb, nb, nc);
    check("b2b start", fc, 4);

    // Header write while busy must be ignored.
    @(negedge clk);
    interest_prefix = PMIS; interest_len = 6'd4; interest_valid = 1;
    @(posedge clk); #1 interest_valid = 0;
    @(negedge clk);
    hdr_we = 1; byte_we = 1; ld_entry = 3'd3; ld_prefix = PNEW; ld_len = 6'd8;
    ld_content_len = 5'd4; ld_addr = '0; ld_byte = 8'h77;
    @(posedge clk); #1 hdr_we = 0; byte_we = 0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (busy && guard < 20);
    check("busy_release", busy, 1'b0);
    run_interest(PNEW, 6'd8, '0, 0, fc, fb, nb, nc);
    check("hdr_while_busy nack_cyc", nc, 8);

    // Content length 0 invalidates an entry.
    load_cycle(1, 0, 2, PA, 6'd16, 0, 0, 8'h00);
    run_interest(PA, 6'd16, '0, 0, fc, fb, nb, nc);
    check("invalidate nack_cyc", nc, 8);
    load_cycle(1, 0, 2, PA, 6'd16, 4, 0, 8'h00);

    // Asynchronous reset on the second streamed byte.
    @(negedge clk);
    interest_prefix = PA; interest_len = 6'd16; interest_valid = 1;
    @(posedge clk); #1 interest_valid = 0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    check("second byte", {data_ready, data_out}, {1'b1, 8'h22});
    #2 rst = 0;
    #1;
    check("async reset", {data_ready, nack, busy, drop_count, data_out, data_prefix}, '0);
    m_drop = 0;
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    @(negedge clk);
    rst = 1;
    run_interest(PA, 6'd16, '0, 0, fc, fb, nb, nc);
    check("after reset nack_cyc", nc, 8);

    // Randomized loads and interests against the model.
    for (int j = 0; j < 4; j++) pool[j] = {32'hC0DE_0000 + 32'(j), $urandom};
    for (int it = 0; it < 30; it++) begin
      int nloads;
      nloads = $urandom_range(0, 2);
      for (int n = 0; n < nloads; n++) begin
        int e, j, clen;
        logic [5:0] l;
        e = $urandom_range(0, ENTRIES - 1);
        j = $urandom_range(0, 3);
        l = ($urandom_range(0, 1) != 0) ? 6'd8 : 6'd16;
        clen = (it < 3) ? $urandom_range(1, 20) : $urandom_range(0, 20);
        for (int a = 0; a < MAX_BYTES; a++) bytes[a] = 8'($urandom);
        load_entry(e, pool[j], l, clen, MAX_BYTES, bytes);
      end
      rmask = (NCYC+1)'($urandom & $urandom & $urandom);
      run_interest(pool[$urandom_range(0, 3)], ($urandom_range(0, 1) != 0) ? 6'd8 : 6'd16,
                   rmask, $urandom_range(0, 1) != 0, fc, fb, nb, nc);
    end
    pending_chain = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
